// File: rtl/pipeline_stall_controller_if.sv
// Hazard/stall handshake bundle between the pipeline stages and the stall controller.
// The master side presents the hazard sources; the slave (controller) returns the pipeline controls.
interface pipeline_stall_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 idExMemRead;
    logic [4:0]           idExRt;
    logic [4:0]           ifIdRs;
    logic [4:0]           ifIdRt;
    logic                 ifIdUsesRt;
    logic                 branchTaken;
    logic                 memBusy;
    logic                 pcWrite;
    logic                 ifIdWrite;
    logic                 bubbleInstruction;
    logic                 ifIdFlush;
    logic                 idExFlush;
    logic                 pipeHold;
    logic [CNT_WIDTH-1:0] stallCount;
    logic [1:0]           state;

    modport master (
        output idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt, branchTaken, memBusy,
        input  pcWrite, ifIdWrite, bubbleInstruction, ifIdFlush, idExFlush, pipeHold,
        input  stallCount, state
    );

    modport slave (
        input  idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt, branchTaken, memBusy,
        output pcWrite, ifIdWrite, bubbleInstruction, ifIdFlush, idExFlush, pipeHold,
        output stallCount, state
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Priority-ordered stall/flush sequencer for a 5-stage pipeline: memory busy > taken branch > load-use,
// with a countdown for multi-bubble loads and a saturating stall-cycle counter.
module pipeline_stall_controller #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stall_controller_if.slave  bus
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_MEMW = 2'd2;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_FLUSH  = 2'd2;
    localparam logic [1:0] MODE_BUBBLE = 2'd3;

    localparam logic [3:0]           LS_INIT = 4'(LOAD_STALL - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]           state_q, state_d;
    logic [1:0]           resume_q, resume_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]           eff_state_s;
    logic [1:0]           mode_s;
    logic                 hazard_s;
    logic                 pc_write_s;

    assign hazard_s = bus.idExMemRead && (bus.idExRt != 5'd0) &&
                      ((bus.idExRt == bus.ifIdRs) ||
                       (bus.ifIdUsesRt && (bus.idExRt == bus.ifIdRt)));

    // Once memory releases, the cycle is handled as if the wait never happened.
    assign eff_state_s = ((state_q == ST_MEMW) && !bus.memBusy) ? resume_q : state_q;

    // Next-state and output-mode selection on the effective state.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        cnt_d    = cnt_q;
        mode_s   = MODE_NORMAL;
        case (eff_state_s)
            ST_RUN: begin
                if (bus.memBusy) begin
                    mode_s   = MODE_HOLD;
                    state_d  = ST_MEMW;
                    resume_d = ST_RUN;
                end else if (bus.branchTaken) begin
                    mode_s  = MODE_FLUSH;
                    state_d = ST_RUN;
                end else if (hazard_s) begin
                    mode_s = MODE_BUBBLE;
                    if (LOAD_STALL == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = LS_INIT;
                        state_d = ST_LOAD;
                    end
                end else begin
                    mode_s  = MODE_NORMAL;
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (bus.memBusy) begin
                    mode_s   = MODE_HOLD;
                    state_d  = ST_MEMW;
                    resume_d = ST_LOAD;
                end else if (bus.branchTaken) begin
                    mode_s  = MODE_FLUSH;
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    mode_s  = MODE_BUBBLE;
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? ST_RUN : ST_LOAD;
                end
            end
            ST_MEMW: begin
                mode_s  = MODE_HOLD;
                state_d = ST_MEMW;
            end
            default: begin
                mode_s   = MODE_HOLD;
                state_d  = ST_RUN;
                resume_d = ST_RUN;
                cnt_d    = 4'd0;
            end
        endcase
    end

    // Decode the selected mode into the pipeline control lines; reset forces the flush/bubble pattern.
    always_comb begin
        bus.pcWrite           = 1'b1;
        bus.ifIdWrite         = 1'b1;
        bus.bubbleInstruction = 1'b0;
        bus.ifIdFlush         = 1'b0;
        bus.idExFlush         = 1'b0;
        bus.pipeHold          = 1'b0;
        if (reset) begin
            bus.pcWrite           = 1'b0;
            bus.ifIdWrite         = 1'b0;
            bus.bubbleInstruction = 1'b1;
            bus.ifIdFlush         = 1'b1;
            bus.idExFlush         = 1'b1;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    bus.pcWrite   = 1'b0;
                    bus.ifIdWrite = 1'b0;
                    bus.pipeHold  = 1'b1;
                end
                MODE_FLUSH: begin
                    bus.ifIdFlush = 1'b1;
                    bus.idExFlush = 1'b1;
                end
                MODE_BUBBLE: begin
                    bus.pcWrite           = 1'b0;
                    bus.ifIdWrite         = 1'b0;
                    bus.bubbleInstruction = 1'b1;
                end
                default: begin
                    bus.pcWrite   = 1'b1;
                    bus.ifIdWrite = 1'b1;
                end
            endcase
        end
    end

    assign pc_write_s = bus.pcWrite;

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, countdown, resume target and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stallCount = stall_cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized and directed bench for pipeline_stall_controller; two instances (LOAD_STALL=1/16-bit,
// LOAD_STALL=3/4-bit counter) share the same stimulus and are each compared to a bubble-budget model.
module tb_pipeline_stall_controller;

    localparam logic [5:0] O_NORMAL = 6'b110000;
    localparam logic [5:0] O_HOLD   = 6'b000001;
    localparam logic [5:0] O_FLUSH  = 6'b110110;
    localparam logic [5:0] O_BUBBLE = 6'b001000;
    localparam logic [5:0] O_RESET  = 6'b001110;

    logic clk;
    logic reset;
    int   total_cnt;
    int   bad_cnt;

    // Model state per instance: bubbles still owed, expected state output, expected stall count.
    int lsp[2];
    int cmax[2];
    int bl[2];
    int st_m[2];
    int cnt_m[2];
    bit valid_m;

    pipeline_stall_controller_if #(.CNT_WIDTH(16)) ifa ();
    pipeline_stall_controller_if #(.CNT_WIDTH(4))  ifb ();

    pipeline_stall_controller #(.LOAD_STALL(1), .CNT_WIDTH(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pipeline_stall_controller #(.LOAD_STALL(3), .CNT_WIDTH(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic eval_inst(input int k);
        logic [5:0] o;
        int s;
        int c;
        logic [5:0] e;
        bit hz;
        string nm;
        nm = (k == 0) ? "A" : "B";
        if (k == 0) begin
            o = {ifa.pcWrite, ifa.ifIdWrite, ifa.bubbleInstruction, ifa.ifIdFlush, ifa.idExFlush, ifa.pipeHold};
            s = int'(ifa.state);
            c = int'(ifa.stallCount);
        end else begin
            o = {ifb.pcWrite, ifb.ifIdWrite, ifb.bubbleInstruction, ifb.ifIdFlush, ifb.idExFlush, ifb.pipeHold};
            s = int'(ifb.state);
            c = int'(ifb.stallCount);
        end
        if (valid_m) begin
            check_val({nm, "_state"}, s, st_m[k]);
            check_val({nm, "_stallCount"}, c, cnt_m[k]);
        end
        if (reset) begin
            check_val({nm, "_reset_ctl"}, int'(o), int'(O_RESET));
            bl[k]    = 0;
            st_m[k]  = 0;
            cnt_m[k] = 0;
        end else begin
            hz = ifa.idExMemRead && (ifa.idExRt != 5'd0) &&
                 (ifa.idExRt == ifa.ifIdRs || (ifa.ifIdUsesRt && ifa.idExRt == ifa.ifIdRt));
            if (ifa.memBusy) begin
                e = O_HOLD;
            end else if (ifa.branchTaken) begin
                e = O_FLUSH;
                bl[k] = 0;
            end else if (bl[k] > 0) begin
                e = O_BUBBLE;
                bl[k]--;
            end else if (hz) begin
                e = O_BUBBLE;
                bl[k] = lsp[k] - 1;
            end else begin
                e = O_NORMAL;
            end
            check_val({nm, "_ctl"}, int'(o), int'(e));
            if (!e[5] && cnt_m[k] < cmax[k]) cnt_m[k]++;
            st_m[k] = ifa.memBusy ? 2 : ((bl[k] > 0) ? 1 : 0);
        end
    endtask

    // One clock cycle: drive both instances on the falling edge, then compare shortly after.
    task automatic cyc(input bit rst, input bit mr, input int rt, input int rs, input int rt2,
                       input bit uses, input bit br, input bit mb);
        @(negedge clk);
        reset           = rst;
        ifa.idExMemRead = mr;   ifb.idExMemRead = mr;
        ifa.idExRt      = 5'(rt);  ifb.idExRt   = 5'(rt);
        ifa.ifIdRs      = 5'(rs);  ifb.ifIdRs   = 5'(rs);
        ifa.ifIdRt      = 5'(rt2); ifb.ifIdRt   = 5'(rt2);
        ifa.ifIdUsesRt  = uses; ifb.ifIdUsesRt  = uses;
        ifa.branchTaken = br;   ifb.branchTaken = br;
        ifa.memBusy     = mb;   ifb.memBusy     = mb;
        #1;
        eval_inst(0);
        eval_inst(1);
        if (rst) valid_m = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        valid_m   = 1'b0;
        lsp[0] = 1;  lsp[1] = 3;
        cmax[0] = 65535; cmax[1] = 15;
        for (int k = 0; k < 2; k++) begin
            bl[k] = 0; st_m[k] = 0; cnt_m[k] = 0;
        end

        // Reset, then idle
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Load-use on rs, then with idExRt=0
        cyc(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0);
        idle(4);
        cyc(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Load-use on rt, with and without ifIdUsesRt
        cyc(1'b0, 1'b1, 7, 1, 7, 1'b1, 1'b0, 1'b0);
        idle(4);
        cyc(1'b0, 1'b1, 7, 1, 7, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Memory busy for 4 cycles during the second bubble
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9, 9, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(4);
        // Branch with hazard; branch while memory busy, then release with branch still high
        cyc(1'b0, 1'b1, 4, 4, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        // Saturate the 4-bit counter, then reset in the middle of a load stall
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(1);
        cyc(1'b0, 1'b1, 3, 3, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Randomized traffic with small register numbers to provoke frequent hazards
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
